// File: rtl/e203_oitf_pkg.sv
// ---------------------------------------------------------------------------
// e203_oitf_pkg
// Shared types and constants for the Outstanding Instruction Track FIFO.
//   oitf_entry_t : payload stored per in-flight long-pipe instruction
//   OITF_DEPTH   : default number of OITF entries
// ---------------------------------------------------------------------------
package e203_oitf_pkg;

    localparam int OITF_DEPTH = 2;

    typedef struct packed {
        logic        rdwen;
        logic        rdfpu;
        logic [4:0]  rdidx;
        logic [31:0] pc;
    } oitf_entry_t;

endpackage

// File: rtl/e203_oitf_entry_match.sv
// ---------------------------------------------------------------------------
// e203_oitf_entry_match
// Compares one OITF entry's destination register against one source/dest
// register query coming from the dispatch stage.
//   vld, rdwen, rdfpu, rdidx : state of the tracked entry
//   q_en, q_idx, q_fpu       : register query (enable, index, file select)
//   hit                      : entry holds a pending write to that register
// ---------------------------------------------------------------------------
module e203_oitf_entry_match (
    input  logic       vld,
    input  logic       rdwen,
    input  logic       rdfpu,
    input  logic [4:0] rdidx,
    input  logic       q_en,
    input  logic [4:0] q_idx,
    input  logic       q_fpu,
    output logic       hit
);

    // An entry that does not write a register can never create a hazard,
    // and integer/FPU files are separate namespaces with the same indices.
    assign hit = vld & rdwen & q_en & (q_idx == rdidx) & (q_fpu == rdfpu);

endmodule

// File: rtl/e203_exu_oitf_trk.sv
// ---------------------------------------------------------------------------
// e203_exu_oitf_trk
// Outstanding Instruction Track FIFO. One entry is allocated per long-pipe
// instruction at dispatch and retired in order at long-pipe writeback. The
// dispatch unit uses the match flags to stall on RAW/WAW hazards.
//
// Ports
//   clk, rst                       : clock, synchronous active-high reset
//   disp_oitf_ena                  : allocate request (gated by ready)
//   disp_oitf_ready                : at least one entry free
//   disp_oitf_ptr                  : itag the next allocation receives
//   disp_oitf_rs{1,2,3}{en,idx,fpu}: source operand queries
//   disp_oitf_rd{wen,idx,fpu}      : destination query / allocation payload
//   disp_oitf_pc                   : PC stored with the allocated entry
//   oitfrd_match_disp{rs1,rs2,rs3,rd}: hazard flags
//   oitf_ret_ena                   : retire the oldest entry
//   oitf_ret_{ptr,rdidx,rdwen,rdfpu,pc}: oldest entry (valid when not empty)
//   oitf_empty                     : no outstanding entries
// ---------------------------------------------------------------------------
module e203_exu_oitf_trk
    import e203_oitf_pkg::*;
#(
    parameter int DEPTH = OITF_DEPTH,
    parameter int PTR_W = $clog2(DEPTH)
) (
    input  logic              clk,
    input  logic              rst,

    input  logic              disp_oitf_ena,
    output logic              disp_oitf_ready,
    output logic [PTR_W-1:0]  disp_oitf_ptr,

    input  logic              disp_oitf_rs1en,
    input  logic              disp_oitf_rs2en,
    input  logic              disp_oitf_rs3en,
    input  logic              disp_oitf_rdwen,
    input  logic [4:0]        disp_oitf_rs1idx,
    input  logic [4:0]        disp_oitf_rs2idx,
    input  logic [4:0]        disp_oitf_rs3idx,
    input  logic [4:0]        disp_oitf_rdidx,
    input  logic              disp_oitf_rs1fpu,
    input  logic              disp_oitf_rs2fpu,
    input  logic              disp_oitf_rs3fpu,
    input  logic              disp_oitf_rdfpu,
    input  logic [31:0]       disp_oitf_pc,

    output logic              oitfrd_match_disprs1,
    output logic              oitfrd_match_disprs2,
    output logic              oitfrd_match_disprs3,
    output logic              oitfrd_match_disprd,

    input  logic              oitf_ret_ena,
    output logic [PTR_W-1:0]  oitf_ret_ptr,
    output logic [4:0]        oitf_ret_rdidx,
    output logic              oitf_ret_rdwen,
    output logic              oitf_ret_rdfpu,
    output logic [31:0]       oitf_ret_pc,
    output logic              oitf_empty
);

    localparam logic [PTR_W-1:0] PTR_LAST = PTR_W'(DEPTH - 1);
    localparam logic [PTR_W-1:0] PTR_ONE  = PTR_W'(1);

    logic [PTR_W-1:0] alc_ptr_reg, alc_ptr_next;
    logic [PTR_W-1:0] ret_ptr_reg, ret_ptr_next;
    logic             alc_flg_reg, alc_flg_next;
    logic             ret_flg_reg, ret_flg_next;
    logic [DEPTH-1:0] vld_reg, vld_next;
    oitf_entry_t      entry_reg [DEPTH];

    logic        full;
    logic        empty;
    logic        alc_fire;
    logic        ret_fire;
    oitf_entry_t alc_entry;

    // Equal pointers mean either empty or full; the wrap flags tell which.
    assign empty = (alc_ptr_reg == ret_ptr_reg) & (alc_flg_reg == ret_flg_reg);
    assign full  = (alc_ptr_reg == ret_ptr_reg) & (alc_flg_reg != ret_flg_reg);

    // Ready depends only on current occupancy: a retire in the same cycle
    // does not free a slot for an allocation until the next cycle.
    assign alc_fire = disp_oitf_ena & ~full;
    assign ret_fire = oitf_ret_ena & ~empty;

    assign alc_entry = '{rdwen: disp_oitf_rdwen,
                         rdfpu: disp_oitf_rdfpu,
                         rdidx: disp_oitf_rdidx,
                         pc:    disp_oitf_pc};

    // Pointer/valid next-state. When neither full nor empty the two pointers
    // differ, so allocate and retire never touch the same valid bit.
    always_comb begin
        alc_ptr_next = alc_ptr_reg;
        alc_flg_next = alc_flg_reg;
        ret_ptr_next = ret_ptr_reg;
        ret_flg_next = ret_flg_reg;
        vld_next     = vld_reg;

        if (alc_fire) begin
            vld_next[alc_ptr_reg] = 1'b1;
            if (alc_ptr_reg == PTR_LAST) begin
                alc_ptr_next = '0;
                alc_flg_next = ~alc_flg_reg;
            end else begin
                alc_ptr_next = alc_ptr_reg + PTR_ONE;
            end
        end

        if (ret_fire) begin
            vld_next[ret_ptr_reg] = 1'b0;
            if (ret_ptr_reg == PTR_LAST) begin
                ret_ptr_next = '0;
                ret_flg_next = ~ret_flg_reg;
            end else begin
                ret_ptr_next = ret_ptr_reg + PTR_ONE;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            alc_ptr_reg <= '0;
            alc_flg_reg <= 1'b0;
            ret_ptr_reg <= '0;
            ret_flg_reg <= 1'b0;
            vld_reg     <= '0;
            // Payload is cleared so the retire outputs read zero after reset.
            for (int i = 0; i < DEPTH; i++) begin
                entry_reg[i] <= '0;
            end
        end else begin
            alc_ptr_reg <= alc_ptr_next;
            alc_flg_reg <= alc_flg_next;
            ret_ptr_reg <= ret_ptr_next;
            ret_flg_reg <= ret_flg_next;
            vld_reg     <= vld_next;
            if (alc_fire) begin
                entry_reg[alc_ptr_reg] <= alc_entry;
            end
        end
    end

    // Hazard detection: every entry is compared against all four queries.
    // Only registered state is used, so an entry allocated this cycle does
    // not see itself.
    logic [DEPTH-1:0] hit_rs1, hit_rs2, hit_rs3, hit_rd;

    generate
        for (genvar gi = 0; gi < DEPTH; gi++) begin : g_entry
            e203_oitf_entry_match u_match_rs1 (
                .vld   (vld_reg[gi]),
                .rdwen (entry_reg[gi].rdwen),
                .rdfpu (entry_reg[gi].rdfpu),
                .rdidx (entry_reg[gi].rdidx),
                .q_en  (disp_oitf_rs1en),
                .q_idx (disp_oitf_rs1idx),
                .q_fpu (disp_oitf_rs1fpu),
                .hit   (hit_rs1[gi])
            );
            e203_oitf_entry_match u_match_rs2 (
                .vld   (vld_reg[gi]),
                .rdwen (entry_reg[gi].rdwen),
                .rdfpu (entry_reg[gi].rdfpu),
                .rdidx (entry_reg[gi].rdidx),
                .q_en  (disp_oitf_rs2en),
                .q_idx (disp_oitf_rs2idx),
                .q_fpu (disp_oitf_rs2fpu),
                .hit   (hit_rs2[gi])
            );
            e203_oitf_entry_match u_match_rs3 (
                .vld   (vld_reg[gi]),
                .rdwen (entry_reg[gi].rdwen),
                .rdfpu (entry_reg[gi].rdfpu),
                .rdidx (entry_reg[gi].rdidx),
                .q_en  (disp_oitf_rs3en),
                .q_idx (disp_oitf_rs3idx),
                .q_fpu (disp_oitf_rs3fpu),
                .hit   (hit_rs3[gi])
            );
            e203_oitf_entry_match u_match_rd (
                .vld   (vld_reg[gi]),
                .rdwen (entry_reg[gi].rdwen),
                .rdfpu (entry_reg[gi].rdfpu),
                .rdidx (entry_reg[gi].rdidx),
                .q_en  (disp_oitf_rdwen),
                .q_idx (disp_oitf_rdidx),
                .q_fpu (disp_oitf_rdfpu),
                .hit   (hit_rd[gi])
            );
        end
    endgenerate

    assign oitfrd_match_disprs1 = |hit_rs1;
    assign oitfrd_match_disprs2 = |hit_rs2;
    assign oitfrd_match_disprs3 = |hit_rs3;
    assign oitfrd_match_disprd  = |hit_rd;

    assign disp_oitf_ready = ~full;
    assign disp_oitf_ptr   = alc_ptr_reg;
    assign oitf_empty      = empty;

    // Oldest entry read straight from the array; when empty this simply
    // shows whatever was last stored at the retire pointer.
    assign oitf_ret_ptr   = ret_ptr_reg;
    assign oitf_ret_rdidx = entry_reg[ret_ptr_reg].rdidx;
    assign oitf_ret_rdwen = entry_reg[ret_ptr_reg].rdwen;
    assign oitf_ret_rdfpu = entry_reg[ret_ptr_reg].rdfpu;
    assign oitf_ret_pc    = entry_reg[ret_ptr_reg].pc;

endmodule

// File: tb/tb_e203_exu_oitf_trk.sv
module tb_e203_exu_oitf_trk;

    localparam int DEPTH = 2;
    localparam int PTR_W = 1;

    logic             clk = 1'b0;
    logic             rst;
    logic             disp_oitf_ena;
    logic             disp_oitf_ready;
    logic [PTR_W-1:0] disp_oitf_ptr;
    logic             disp_oitf_rs1en, disp_oitf_rs2en, disp_oitf_rs3en, disp_oitf_rdwen;
    logic [4:0]       disp_oitf_rs1idx, disp_oitf_rs2idx, disp_oitf_rs3idx, disp_oitf_rdidx;
    logic             disp_oitf_rs1fpu, disp_oitf_rs2fpu, disp_oitf_rs3fpu, disp_oitf_rdfpu;
    logic [31:0]      disp_oitf_pc;
    logic             oitfrd_match_disprs1, oitfrd_match_disprs2;
    logic             oitfrd_match_disprs3, oitfrd_match_disprd;
    logic             oitf_ret_ena;
    logic [PTR_W-1:0] oitf_ret_ptr;
    logic [4:0]       oitf_ret_rdidx;
    logic             oitf_ret_rdwen, oitf_ret_rdfpu;
    logic [31:0]      oitf_ret_pc;
    logic             oitf_empty;

    always #5 clk = ~clk;

    e203_exu_oitf_trk #(.DEPTH(DEPTH), .PTR_W(PTR_W)) dut (
        .clk                  (clk),
        .rst                  (rst),
        .disp_oitf_ena        (disp_oitf_ena),
        .disp_oitf_ready      (disp_oitf_ready),
        .disp_oitf_ptr        (disp_oitf_ptr),
        .disp_oitf_rs1en      (disp_oitf_rs1en),
        .disp_oitf_rs2en      (disp_oitf_rs2en),
        .disp_oitf_rs3en      (disp_oitf_rs3en),
        .disp_oitf_rdwen      (disp_oitf_rdwen),
        .disp_oitf_rs1idx     (disp_oitf_rs1idx),
        .disp_oitf_rs2idx     (disp_oitf_rs2idx),
        .disp_oitf_rs3idx     (disp_oitf_rs3idx),
        .disp_oitf_rdidx      (disp_oitf_rdidx),
        .disp_oitf_rs1fpu     (disp_oitf_rs1fpu),
        .disp_oitf_rs2fpu     (disp_oitf_rs2fpu),
        .disp_oitf_rs3fpu     (disp_oitf_rs3fpu),
        .disp_oitf_rdfpu      (disp_oitf_rdfpu),
        .disp_oitf_pc         (disp_oitf_pc),
        .oitfrd_match_disprs1 (oitfrd_match_disprs1),
        .oitfrd_match_disprs2 (oitfrd_match_disprs2),
        .oitfrd_match_disprs3 (oitfrd_match_disprs3),
        .oitfrd_match_disprd  (oitfrd_match_disprd),
        .oitf_ret_ena         (oitf_ret_ena),
        .oitf_ret_ptr         (oitf_ret_ptr),
        .oitf_ret_rdidx       (oitf_ret_rdidx),
        .oitf_ret_rdwen       (oitf_ret_rdwen),
        .oitf_ret_rdfpu       (oitf_ret_rdfpu),
        .oitf_ret_pc          (oitf_ret_pc),
        .oitf_empty           (oitf_empty)
    );

    // Expected observable outputs for one cycle; match = {rs1,rs2,rs3,rd}.
    typedef struct packed {
        logic             ready;
        logic [PTR_W-1:0] ptr;
        logic             empty;
        logic [3:0]       match;
        logic [PTR_W-1:0] rptr;
        logic [4:0]       rdidx;
        logic             rdwen;
        logic             rdfpu;
        logic [31:0]      pc;
    } exp_t;

    exp_t  exp_q  [$];
    string name_q [$];
    int    total = 0;
    int    bad   = 0;

    function automatic exp_t mk(logic rdy, logic ptr, logic emp, logic [3:0] m,
                                logic rp, logic [4:0] ri, logic rw, logic rf,
                                logic [31:0] pc);
        exp_t e;
        e.ready = rdy; e.ptr = ptr; e.empty = emp; e.match = m;
        e.rptr = rp; e.rdidx = ri; e.rdwen = rw; e.rdfpu = rf; e.pc = pc;
        return e;
    endfunction

    // Monitor: samples combinational outputs mid-cycle and checks against
    // whatever the stimulus queued for this cycle.
    always @(negedge clk) begin
        if (exp_q.size() > 0) begin
            exp_t  e;
            exp_t  got;
            string n;
            e = exp_q.pop_front();
            n = name_q.pop_front();
            got.ready = disp_oitf_ready;
            got.ptr   = disp_oitf_ptr;
            got.empty = oitf_empty;
            got.match = {oitfrd_match_disprs1, oitfrd_match_disprs2,
                         oitfrd_match_disprs3, oitfrd_match_disprd};
            got.rptr  = oitf_ret_ptr;
            got.rdidx = oitf_ret_rdidx;
            got.rdwen = oitf_ret_rdwen;
            got.rdfpu = oitf_ret_rdfpu;
            got.pc    = oitf_ret_pc;
            total++;
            if (got !== e) begin
                bad++;
                $display("FAIL %s: got rdy=%b ptr=%0d emp=%b m=%b rptr=%0d rd=%0d wen=%b fpu=%b pc=%h ; want rdy=%b ptr=%0d emp=%b m=%b rptr=%0d rd=%0d wen=%b fpu=%b pc=%h",
                         n, got.ready, got.ptr, got.empty, got.match, got.rptr, got.rdidx,
                         got.rdwen, got.rdfpu, got.pc, e.ready, e.ptr, e.empty, e.match,
                         e.rptr, e.rdidx, e.rdwen, e.rdfpu, e.pc);
            end else begin
                $display("ok   %s: rdy=%b ptr=%0d emp=%b m=%b rptr=%0d rd=%0d pc=%h",
                         n, got.ready, got.ptr, got.empty, got.match, got.rptr,
                         got.rdidx, got.pc);
            end
        end
    end

    task automatic idle();
        disp_oitf_ena = 0; oitf_ret_ena = 0;
        disp_oitf_rs1en = 0; disp_oitf_rs2en = 0; disp_oitf_rs3en = 0; disp_oitf_rdwen = 0;
        disp_oitf_rs1idx = 0; disp_oitf_rs2idx = 0; disp_oitf_rs3idx = 0; disp_oitf_rdidx = 0;
        disp_oitf_rs1fpu = 0; disp_oitf_rs2fpu = 0; disp_oitf_rs3fpu = 0; disp_oitf_rdfpu = 0;
        disp_oitf_pc = 0;
    endtask

    // Inputs are already applied; queue the expectation and run one cycle.
    task automatic cyc(string n, exp_t e);
        exp_q.push_back(e);
        name_q.push_back(n);
        @(posedge clk);
        #1;
        idle();
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "timeout");
    end

    initial begin
        idle();
        rst = 1;
        repeat (3) @(posedge clk);
        #1;
        rst = 0;

        cyc("reset_state", mk(1, 0, 1, 4'b0000, 0, 0, 0, 0, 32'h0));

        // Allocate A: rd x5; an entry being allocated must not match itself.
        disp_oitf_ena = 1; disp_oitf_rdwen = 1; disp_oitf_rdidx = 5; disp_oitf_pc = 32'h8000_0010;
        cyc("alloc_a_no_self", mk(1, 0, 1, 4'b0000, 0, 0, 0, 0, 32'h0));

        disp_oitf_rs1en = 1; disp_oitf_rs1idx = 5; disp_oitf_rdwen = 1; disp_oitf_rdidx = 5;
        disp_oitf_rs2en = 1; disp_oitf_rs2idx = 6;
        cyc("raw_waw_hit", mk(1, 1, 0, 4'b1001, 0, 5, 1, 0, 32'h8000_0010));

        disp_oitf_rs1en = 0; disp_oitf_rs1idx = 5;
        disp_oitf_rs3en = 1; disp_oitf_rs3idx = 5; disp_oitf_rs3fpu = 1;
        disp_oitf_rdwen = 0; disp_oitf_rdidx = 5;
        cyc("en_off_fpu_mismatch", mk(1, 1, 0, 4'b0000, 0, 5, 1, 0, 32'h8000_0010));

        // Allocate B: rdwen=0 x7; rs2 still sees A.
        disp_oitf_ena = 1; disp_oitf_rdwen = 0; disp_oitf_rdidx = 7; disp_oitf_pc = 32'h8000_0020;
        disp_oitf_rs2en = 1; disp_oitf_rs2idx = 5;
        cyc("alloc_b", mk(1, 1, 0, 4'b0100, 0, 5, 1, 0, 32'h8000_0010));

        // Full: third allocation must be dropped; rdwen=0 entry never matches.
        disp_oitf_ena = 1; disp_oitf_rdwen = 1; disp_oitf_rdidx = 9; disp_oitf_pc = 32'h8000_0030;
        disp_oitf_rs1en = 1; disp_oitf_rs1idx = 7;
        cyc("full_alloc_drop", mk(0, 0, 0, 4'b0000, 0, 5, 1, 0, 32'h8000_0010));

        disp_oitf_rs1en = 1; disp_oitf_rs1idx = 9;
        cyc("full_unchanged", mk(0, 0, 0, 4'b0000, 0, 5, 1, 0, 32'h8000_0010));

        // Full with alloc+retire: retire only.
        disp_oitf_ena = 1; oitf_ret_ena = 1; disp_oitf_rdwen = 1; disp_oitf_rdidx = 11;
        disp_oitf_pc = 32'h8000_0040;
        cyc("full_alloc_ret", mk(0, 0, 0, 4'b0000, 0, 5, 1, 0, 32'h8000_0010));

        disp_oitf_rs1en = 1; disp_oitf_rs1idx = 5; disp_oitf_rdwen = 1; disp_oitf_rdidx = 11;
        cyc("after_full_ret", mk(1, 0, 0, 4'b0000, 1, 7, 0, 0, 32'h8000_0020));

        // Steady state at occupancy 1: alloc+retire each cycle.
        for (int k = 0; k < 8; k++) begin
            exp_t e;
            disp_oitf_ena = 1; oitf_ret_ena = 1;
            disp_oitf_rdwen = 1; disp_oitf_rdidx = 5'(16 + k);
            disp_oitf_pc = 32'h8000_0100 + 32'(4 * k);
            disp_oitf_rs1en = 1; disp_oitf_rs1idx = 5'(16 + k);
            disp_oitf_rs2en = 1;
            if (k == 0) begin
                disp_oitf_rs2idx = 7;
                e = mk(1, 0, 0, 4'b0000, 1, 7, 0, 0, 32'h8000_0020);
            end else begin
                disp_oitf_rs2idx = 5'(16 + k - 1);
                e = mk(1, 1'(k % 2), 0, 4'b0100, 1'((1 + k) % 2), 5'(16 + k - 1), 1, 0,
                       32'h8000_0100 + 32'(4 * (k - 1)));
            end
            cyc($sformatf("steady_%0d", k), e);
        end

        oitf_ret_ena = 1;
        cyc("drain_last", mk(1, 0, 0, 4'b0000, 1, 23, 1, 0, 32'h8000_011C));

        oitf_ret_ena = 1; disp_oitf_rs1en = 1; disp_oitf_rs1idx = 23;
        cyc("ret_while_empty", mk(1, 0, 1, 4'b0000, 0, 22, 1, 0, 32'h8000_0118));

        cyc("empty_unchanged", mk(1, 0, 1, 4'b0000, 0, 22, 1, 0, 32'h8000_0118));

        // FPU destination entry.
        disp_oitf_ena = 1; disp_oitf_rdwen = 1; disp_oitf_rdidx = 3; disp_oitf_rdfpu = 1;
        disp_oitf_pc = 32'h8000_0200;
        cyc("alloc_fpu", mk(1, 0, 1, 4'b0000, 0, 22, 1, 0, 32'h8000_0118));

        disp_oitf_rdwen = 1; disp_oitf_rdidx = 3; disp_oitf_rdfpu = 0;
        disp_oitf_rs1en = 1; disp_oitf_rs1idx = 3; disp_oitf_rs1fpu = 1;
        disp_oitf_rs2en = 1; disp_oitf_rs2idx = 3; disp_oitf_rs2fpu = 0;
        cyc("fpu_select", mk(1, 1, 0, 4'b1000, 0, 3, 1, 1, 32'h8000_0200));

        // Reset mid-operation with alloc and retire requested.
        rst = 1; disp_oitf_ena = 1; oitf_ret_ena = 1; disp_oitf_rdwen = 1;
        disp_oitf_rdidx = 12; disp_oitf_pc = 32'h8000_0300;
        cyc("mid_reset_cycle", mk(1, 1, 0, 4'b0000, 0, 3, 1, 1, 32'h8000_0200));
        rst = 0;

        disp_oitf_rdwen = 1; disp_oitf_rdidx = 12; disp_oitf_rs1en = 1; disp_oitf_rs1idx = 3;
        disp_oitf_rs1fpu = 1;
        cyc("after_mid_reset", mk(1, 0, 1, 4'b0000, 0, 0, 0, 0, 32'h0));

        // Every queued expectation must have been consumed by the monitor.
        @(negedge clk);
        #1;
        total++;
        if (exp_q.size() != 0) begin
            bad++;
            $display("FAIL scoreboard_drain: got %0d pending, want 0", exp_q.size());
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
